// File: rtl/kbd_pkg.sv
// Shared key codes, controller state encoding and display constants for the keypad calculator.
package kbd_pkg;

   typedef enum logic [1:0] {
      S_A    = 2'd0,
      S_B    = 2'd1,
      S_CALC = 2'd2,
      S_RES  = 2'd3
   } state_t;

   localparam logic [3:0] KEY_ADD = 4'hA;
   localparam logic [3:0] KEY_SUB = 4'hB;
   localparam logic [3:0] KEY_ENT = 4'hE;
   localparam logic [3:0] KEY_CLR = 4'hF;
   localparam logic [3:0] BLANK   = 4'hF;

   function automatic logic is_digit(input logic [3:0] code);
      return code <= 4'd9;
   endfunction

endpackage

// File: rtl/bcd_shift2.sv
// Two-digit BCD entry register: new digit enters the ones place, old tens falls off.
// One-cycle update; clr together with load_en yields {0, digit}; no backpressure.
module bcd_shift2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       load_en,
   input  logic [3:0] digit,
   output logic [7:0] val
);

   logic [7:0] val_q;
   logic [7:0] val_d;
   logic [7:0] base;

   always_comb begin
      base  = clr ? 8'h00 : val_q;
      val_d = load_en ? {base[3:0], digit} : base;
   end

   always_ff @(posedge clk) begin
      if (rst) val_q <= 8'h00;
      else     val_q <= val_d;
   end

   assign val = val_q;

endmodule

// File: rtl/key_entry_ctrl.sv
// Keypad sequencer: builds operand A, operator, operand B, starts the BCD unit and shows the result.
// Key effects visible one cycle after the sampling edge; no backpressure, every strobe is consumed.
module key_entry_ctrl
   import kbd_pkg::*;
#(
   parameter int DIGITS = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_pulse,
   input  logic [3:0]  key_code,
   output logic        calc_start,
   input  logic        calc_done,
   input  logic [15:0] result_bcd,
   output logic [7:0]  op_a,
   output logic [7:0]  op_b,
   output logic        op_sel,
   output logic [15:0] disp,
   output logic [1:0]  state_o
);

   if (DIGITS != 2) begin : g_digits_check
      $error("key_entry_ctrl supports DIGITS == 2 only");
   end

   state_t      state_q, state_d;
   logic        sel_q, sel_d;
   logic        start_q, start_d;
   logic [15:0] res_q, res_d;
   logic        a_clr, a_ld, b_clr, b_ld;
   logic        key_dig, key_op, key_ent, key_clr;

   always_comb begin
      key_dig = key_pulse && is_digit(key_code);
      key_op  = key_pulse && (key_code == KEY_ADD || key_code == KEY_SUB);
      key_ent = key_pulse && (key_code == KEY_ENT);
      key_clr = key_pulse && (key_code == KEY_CLR);
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      res_d   = res_q;
      start_d = 1'b0;
      a_clr   = 1'b0;
      a_ld    = 1'b0;
      b_clr   = 1'b0;
      b_ld    = 1'b0;
      unique case (state_q)
         S_A: begin
            if (key_dig) begin
               a_ld = 1'b1;
            end else if (key_op) begin
               sel_d   = (key_code == KEY_SUB);
               b_clr   = 1'b1;
               state_d = S_B;
            end else if (key_clr) begin
               a_clr = 1'b1;
            end
         end
         S_B: begin
            if (key_dig) begin
               b_ld = 1'b1;
            end else if (key_op) begin
               sel_d = (key_code == KEY_SUB);
            end else if (key_ent) begin
               start_d = 1'b1;
               state_d = S_CALC;
            end else if (key_clr) begin
               a_clr   = 1'b1;
               b_clr   = 1'b1;
               sel_d   = 1'b0;
               state_d = S_A;
            end
         end
         S_CALC: begin
            // Abort beats a coincident completion; the result is discarded.
            if (key_clr) begin
               a_clr   = 1'b1;
               b_clr   = 1'b1;
               sel_d   = 1'b0;
               res_d   = 16'h0000;
               state_d = S_A;
            end else if (calc_done) begin
               res_d   = result_bcd;
               state_d = S_RES;
            end
         end
         S_RES: begin
            if (key_dig) begin
               a_clr   = 1'b1;
               a_ld    = 1'b1;
               b_clr   = 1'b1;
               sel_d   = 1'b0;
               state_d = S_A;
            end else if (key_clr) begin
               a_clr   = 1'b1;
               b_clr   = 1'b1;
               sel_d   = 1'b0;
               res_d   = 16'h0000;
               state_d = S_A;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_A;
         sel_q   <= 1'b0;
         start_q <= 1'b0;
         res_q   <= 16'h0000;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         start_q <= start_d;
         res_q   <= res_d;
      end
   end

   bcd_shift2 u_op_a (
      .clk     (clk),
      .rst     (rst),
      .clr     (a_clr),
      .load_en (a_ld),
      .digit   (key_code),
      .val     (op_a)
   );

   bcd_shift2 u_op_b (
      .clk     (clk),
      .rst     (rst),
      .clr     (b_clr),
      .load_en (b_ld),
      .digit   (key_code),
      .val     (op_b)
   );

   always_comb begin
      unique case (state_q)
         S_A:          disp = {BLANK, BLANK, op_a};
         S_B, S_CALC:  disp = {BLANK, BLANK, op_b};
         S_RES:        disp = res_q;
      endcase
   end

   assign calc_start = start_q;
   assign op_sel     = sel_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed plus randomized bench for key_entry_ctrl against a decimal-arithmetic reference model.
module tb_key_entry_ctrl;

   logic        clk;
   logic        rst;
   logic        key_pulse;
   logic [3:0]  key_code;
   logic        calc_start;
   logic        calc_done;
   logic [15:0] result_bcd;
   logic [7:0]  op_a;
   logic [7:0]  op_b;
   logic        op_sel;
   logic [15:0] disp;
   logic [1:0]  state_o;

   key_entry_ctrl #(.DIGITS(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .key_pulse  (key_pulse),
      .key_code   (key_code),
      .calc_start (calc_start),
      .calc_done  (calc_done),
      .result_bcd (result_bcd),
      .op_a       (op_a),
      .op_b       (op_b),
      .op_sel     (op_sel),
      .disp       (disp),
      .state_o    (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: operands kept as plain decimal numbers 0..99.
   int m_mode  = 0;
   int m_a     = 0;
   int m_b     = 0;
   int m_sel   = 0;
   int m_res   = 0;
   int m_start = 0;

   function automatic int to_bcd2(input int x);
      return ((x / 10) << 4) | (x % 10);
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic model_update(input bit r, input bit p, input int code, input bit d, input int res);
      int nxt_start;
      nxt_start = 0;
      if (r) begin
         m_mode = 0; m_a = 0; m_b = 0; m_sel = 0; m_res = 0;
      end else begin
         case (m_mode)
            0: if (p) begin
                  if (code <= 9) m_a = (m_a % 10) * 10 + code;
                  else if (code == 10 || code == 11) begin
                     m_sel = (code == 11); m_b = 0; m_mode = 1;
                  end else if (code == 15) m_a = 0;
               end
            1: if (p) begin
                  if (code <= 9) m_b = (m_b % 10) * 10 + code;
                  else if (code == 10 || code == 11) m_sel = (code == 11);
                  else if (code == 14) begin m_mode = 2; nxt_start = 1; end
                  else if (code == 15) begin m_a = 0; m_b = 0; m_sel = 0; m_mode = 0; end
               end
            2: if (p && code == 15) begin
                  m_a = 0; m_b = 0; m_sel = 0; m_res = 0; m_mode = 0;
               end else if (d) begin
                  m_res = res; m_mode = 3;
               end
            default: if (p) begin
                  if (code <= 9) begin m_a = code; m_b = 0; m_sel = 0; m_mode = 0; end
                  else if (code == 15) begin m_a = 0; m_b = 0; m_sel = 0; m_res = 0; m_mode = 0; end
               end
         endcase
      end
      m_start = nxt_start;
   endtask

   task automatic compare_all();
      logic [15:0] exp_disp;
      if (m_mode == 0)      exp_disp = 16'hFF00 | 16'(to_bcd2(m_a));
      else if (m_mode == 3) exp_disp = 16'(m_res);
      else                  exp_disp = 16'hFF00 | 16'(to_bcd2(m_b));
      chk("calc_start", {15'd0, calc_start}, 16'(m_start));
      chk("op_a",       {8'd0, op_a},        16'(to_bcd2(m_a)));
      chk("op_b",       {8'd0, op_b},        16'(to_bcd2(m_b)));
      chk("op_sel",     {15'd0, op_sel},     16'(m_sel));
      chk("state_o",    {14'd0, state_o},    16'(m_mode));
      chk("disp",       disp,                exp_disp);
   endtask

   // One clock: drive at the falling edge, model at the rising edge, compare just after it.
   task automatic step(input bit r, input bit p, input int code, input bit d, input int res);
      rst        = r;
      key_pulse  = p;
      key_code   = 4'(code);
      calc_done  = d;
      result_bcd = 16'(res);
      @(posedge clk);
      model_update(r, p, code, d, res);
      #1;
      compare_all();
      @(negedge clk);
   endtask

   task automatic key(input int code);
      step(1'b0, 1'b1, code, 1'b0, 0);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 0, 1'b0, 0);
   endtask

   function automatic int rand_bcd4();
      int v;
      v = 0;
      for (int i = 0; i < 4; i++) v = (v << 4) | int'($urandom_range(0, 9));
      return v;
   endfunction

   initial begin
      rst = 1'b1; key_pulse = 1'b0; key_code = 4'h0; calc_done = 1'b0; result_bcd = 16'h0;
      @(negedge clk);
      step(1'b1, 1'b0, 0, 1'b0, 0);
      chk("rst_state", {14'd0, state_o}, 16'd0);
      chk("rst_disp", disp, 16'hFF00);
      chk("rst_start", {15'd0, calc_start}, 16'd0);

      // 12 + 34
      key(1); key(2); key(10); key(3); key(4); key(14);
      chk("start_hi", {15'd0, calc_start}, 16'd1);
      chk("calc_state", {14'd0, state_o}, 16'd2);
      idle();
      chk("start_lo", {15'd0, calc_start}, 16'd0);
      step(1'b0, 1'b0, 0, 1'b1, 16'h0046);
      chk("res_disp", disp, 16'h0046);
      chk("res_op_a", {8'd0, op_a}, 16'h0012);
      chk("res_op_b", {8'd0, op_b}, 16'h0034);
      chk("res_sel", {15'd0, op_sel}, 16'd0);

      // tens digit drops off
      key(15); key(9); key(8); key(7);
      chk("shift_op_a", {8'd0, op_a}, 16'h0087);
      chk("shift_disp", disp, 16'hFF87);

      // last operator wins
      key(5); key(11); key(10); key(2); key(14);
      chk("lastop_sel", {15'd0, op_sel}, 16'd0);
      chk("lastop_b", {8'd0, op_b}, 16'h0002);
      chk("lastop_state", {14'd0, state_o}, 16'd2);

      // abort coincident with done
      step(1'b0, 1'b1, 15, 1'b1, 16'h1234);
      chk("abort_state", {14'd0, state_o}, 16'd0);
      chk("abort_disp", disp, 16'hFF00);
      chk("abort_a", {8'd0, op_a}, 16'h0000);
      step(1'b0, 1'b0, 0, 1'b1, 16'h5555);
      chk("late_done_state", {14'd0, state_o}, 16'd0);

      // digit in result view starts a new operand A
      key(1); key(10); key(1); key(14); idle();
      step(1'b0, 1'b0, 0, 1'b1, 16'h0002);
      key(7);
      chk("resdig_state", {14'd0, state_o}, 16'd0);
      chk("resdig_a", {8'd0, op_a}, 16'h0007);
      chk("resdig_b", {8'd0, op_b}, 16'h0000);
      chk("resdig_disp", disp, 16'hFF07);

      // reset while a calculation is pending
      key(2); key(10); key(3); key(14);
      step(1'b1, 1'b0, 0, 1'b0, 0);
      chk("rst_mid_state", {14'd0, state_o}, 16'd0);
      chk("rst_mid_start", {15'd0, calc_start}, 16'd0);
      chk("rst_mid_disp", disp, 16'hFF00);
      step(1'b0, 1'b0, 0, 1'b1, 16'h0099);
      chk("rst_late_done", {14'd0, state_o}, 16'd0);

      // randomized traffic, including back-to-back keys and stray completions
      for (int i = 0; i < 4000; i++) begin
         step(($urandom_range(0, 199) == 0),
              ($urandom_range(0, 2) == 0),
              int'($urandom_range(0, 15)),
              ($urandom_range(0, 5) == 0),
              rand_bcd4());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
